// File: rtl/sdram_arb_pkg.sv
// Shared widths, state encoding and index-width helper for the SDRAM slot arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Width of an index able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester found searching upward from ptr+1 with wrap.
module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_vec,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mask_port0,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    int w_dist;
    int w_best;

    // Each port's distance from ptr+1 modulo N; the eligible port with the smallest distance wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_dist      = 0;
        w_best      = N;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + 2 * N - int'(ptr) - 1) % N;
            if (req_vec[i] && !(mask_port0 && (i == 0)) && (w_dist < w_best)) begin
                w_best      = w_dist;
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Slot-aligned arbiter sharing one byte-wide SDRAM controller port among NUM_REQ requesters,
// with optional CPU priority and a forced idle slot after MAX_BUSY_SLOTS consecutive grants.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int CPU_PRIORITY   = 1,
    parameter int MAX_BUSY_SLOTS = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clkref,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_din,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    output logic                      mem_oe,
    output logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = idx_w(MAX_BUSY_SLOTS + 1);

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic                      r_clkref_d;
    logic [IDX_W-1:0]          r_grant;
    logic [IDX_W-1:0]          r_ptr;
    logic [CNT_W-1:0]          r_busy_cnt;
    logic [NUM_REQ-1:0]        r_ack;
    logic [NUM_REQ*DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [DATA_W-1:0]         r_mem_din;
    logic                      r_mem_oe;
    logic                      r_mem_we;

    logic                      w_sb;
    logic [NUM_REQ-1:0]        w_ack_mask;
    logic [NUM_REQ-1:0]        w_elig;
    logic                      w_mask_p0;
    logic                      w_cpu_win;
    logic                      w_rr_valid;
    logic [IDX_W-1:0]          w_rr_idx;
    logic                      w_win;
    logic [IDX_W-1:0]          w_win_idx;
    logic                      w_refresh;
    logic                      w_grant;
    logic [ADDR_W-1:0]         w_sel_addr;
    logic [DATA_W-1:0]         w_sel_din;
    logic                      w_sel_we;

    assign w_sb       = clkref & ~r_clkref_d;
    // The port completing in this slot sits out the arbitration held in the same cycle.
    assign w_ack_mask = (r_state == ST_BUSY) ? (NUM_REQ'(1) << r_grant) : '0;
    assign w_elig     = req & ~w_ack_mask;
    assign w_mask_p0  = (CPU_PRIORITY != 0);
    assign w_cpu_win  = w_mask_p0 & w_elig[0];
    assign w_win      = w_cpu_win | w_rr_valid;
    assign w_win_idx  = w_cpu_win ? '0 : w_rr_idx;
    assign w_refresh  = (r_busy_cnt == CNT_W'(MAX_BUSY_SLOTS));
    assign w_grant    = w_win & ~w_refresh;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_vec     (w_elig),
        .ptr         (r_ptr),
        .mask_port0  (w_mask_p0),
        .grant_valid (w_rr_valid),
        .grant_idx   (w_rr_idx)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_din  = '0;
        w_sel_we   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_din  = req_din[i*DATA_W +: DATA_W];
                w_sel_we   = req_we[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_sb) begin
            w_state_nxt = w_grant ? ST_BUSY : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clkref_d <= 1'b0;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_busy_cnt <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_oe   <= 1'b0;
            r_mem_we   <= 1'b0;
        end else begin
            r_clkref_d <= clkref;
            r_ack      <= '0;
            if (w_sb) begin
                // Completion uses the controller data still driven for the access now ending.
                if (r_state == ST_BUSY) begin
                    r_ack <= w_ack_mask;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_ack_mask[i] && !r_mem_we) begin
                            r_rdata[i*DATA_W +: DATA_W] <= mem_dout;
                        end
                    end
                end
                if (w_grant) begin
                    r_grant    <= w_win_idx;
                    r_ptr      <= w_win_idx;
                    r_mem_addr <= w_sel_addr;
                    r_mem_din  <= w_sel_din;
                    r_mem_oe   <= ~w_sel_we;
                    r_mem_we   <= w_sel_we;
                    r_busy_cnt <= r_busy_cnt + 1'b1;
                end else begin
                    r_mem_oe   <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_busy_cnt <= '0;
                end
            end
        end
    end

    assign ack      = r_ack;
    assign rdata    = r_rdata;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_oe   = r_mem_oe;
    assign mem_we   = r_mem_we;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a CPU-priority instance and a pure round-robin instance on shared stimulus.
module tb_sdram_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           clkref;
    logic [N-1:0]   req;
    logic [N-1:0]   req_we;
    logic [N*25-1:0] req_addr;
    logic [N*8-1:0] req_din;

    logic [N-1:0]   ack_p, ack_r;
    logic [N*8-1:0] rdata_p, rdata_r;
    logic [24:0]    maddr_p, maddr_r;
    logic [7:0]     mdin_p, mdin_r;
    logic           moe_p, mwe_p, moe_r, mwe_r;
    logic [7:0]     mdout_p, mdout_r;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          port;
        logic        we;
        logic [24:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_rd;
    } vec_t;

    typedef struct {
        int         port;
        logic [7:0] rd;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_model(input logic [24:0] a);
        return a[7:0] ^ 8'h79;
    endfunction

    assign mdout_p = moe_p ? mem_model(maddr_p) : 8'hFF;
    assign mdout_r = moe_r ? mem_model(maddr_r) : 8'hFF;

    sdram_arbiter #(.NUM_REQ(N), .CPU_PRIORITY(1), .MAX_BUSY_SLOTS(32)) dut (
        .clk(clk), .reset_n(reset_n), .clkref(clkref),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .ack(ack_p), .rdata(rdata_p),
        .mem_addr(maddr_p), .mem_din(mdin_p), .mem_oe(moe_p), .mem_we(mwe_p),
        .mem_dout(mdout_p)
    );

    sdram_arbiter #(.NUM_REQ(N), .CPU_PRIORITY(0), .MAX_BUSY_SLOTS(32)) dut_rr (
        .clk(clk), .reset_n(reset_n), .clkref(clkref),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .ack(ack_r), .rdata(rdata_r),
        .mem_addr(maddr_r), .mem_din(mdin_r), .mem_oe(moe_r), .mem_we(mwe_r),
        .mem_dout(mdout_r)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Raise clkref; return at the falling clk edge right after the slot-boundary edge.
    task automatic tick_slot();
        @(negedge clk);
        clkref = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_slot();
        @(negedge clk);
        clkref = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic we, input logic [24:0] a, input logic [7:0] d);
        req_we[p]          = we;
        req_addr[p*25 +: 25] = a;
        req_din[p*8 +: 8]  = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clkref  = 1'b0;
        req     = '0;
        repeat (3) @(negedge clk);
        sbq.delete();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_ack(input bit due, input string nm);
        exp_t e;
        if (!due) begin
            chk({nm, "_noack"}, 32'(ack_p), 32'd0);
        end else if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_queue: got ack 0x%0h, want a pending transaction", nm, ack_p);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_ack"}, 32'(ack_p), 32'(1) << e.port);
            chk({nm, "_rdata"}, 32'(rdata_p[e.port*8 +: 8]), 32'(e.rd));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr, prev_r, prev_p, g, prev;
        exp_t e;

        req_we   = '0;
        req_addr = '0;
        req_din  = '0;
        req      = '0;
        clkref   = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        chk("rst_ack",    32'(ack_p),   32'd0);
        chk("rst_rdata",  32'(rdata_p), 32'd0);
        chk("rst_oe",     32'(moe_p),   32'd0);
        chk("rst_we",     32'(mwe_p),   32'd0);
        chk("rst_addr",   32'(maddr_p), 32'd0);
        chk("rst_din",    32'(mdin_p),  32'd0);
        chk("rst_rr_oe",  32'(moe_r),   32'd0);
        chk("rst_rr_ack", 32'(ack_r),   32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // All three ports held for 40 slots: round-robin order and the forced refresh slot.
        for (int p = 0; p < N; p++) set_port(p, 1'b0, 25'h10 + 25'(p) * 25'h100, 8'h00);
        req    = 3'b111;
        exp_rr = 1;
        prev_r = -1;
        prev_p = -1;
        for (int s = 1; s <= 40; s++) begin
            tick_slot();
            chk("rr_ack", 32'(ack_r), (prev_r < 0) ? 32'd0 : (32'd1 << prev_r));
            if (s == 33) begin
                chk("rr_refresh_oe",  32'(moe_r), 32'd0);
                chk("cpu_refresh_oe", 32'(moe_p), 32'd0);
                prev_r = -1;
                prev_p = -1;
            end else begin
                chk("rr_oe",    32'(moe_r), 32'd1);
                chk("rr_order", 32'(maddr_r[9:8]), 32'(exp_rr));
                prev_r = exp_rr;
                exp_rr = (exp_rr + 1) % N;
                chk("cpu_oe", 32'(moe_p), 32'd1);
                if (prev_p == 0) begin
                    chk("cpu_yield_not0", 32'(maddr_p[9:8] == 2'd0), 32'd0);
                    prev_p = int'(maddr_p[9:8]);
                end else begin
                    chk("cpu_wins", 32'(maddr_p), 32'h010);
                    prev_p = 0;
                end
            end
            end_slot();
        end
        req = '0;
        repeat (2) begin tick_slot(); end_slot(); end

        // Single transactions from the vector table, one at a time.
        do_reset();
        vecs[0] = '{1, 1'b0, 25'h0000123, 8'h00, 8'h5A};
        vecs[1] = '{0, 1'b1, 25'h1FFFFFF, 8'hC3, 8'h00};
        vecs[2] = '{2, 1'b0, 25'h00ABCDE, 8'h00, 8'hA7};
        vecs[3] = '{0, 1'b0, 25'h00000FF, 8'h00, 8'h86};
        vecs[4] = '{2, 1'b1, 25'h1000000, 8'h00, 8'hA7};
        vecs[5] = '{1, 1'b0, 25'h1555579, 8'h00, 8'h00};
        for (int v = 0; v < 6; v++) begin
            set_port(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].din);
            req[vecs[v].port] = 1'b1;
            tick_slot();
            chk("vec_oe",   32'(moe_p),   32'(!vecs[v].we));
            chk("vec_we",   32'(mwe_p),   32'(vecs[v].we));
            chk("vec_addr", 32'(maddr_p), 32'(vecs[v].addr));
            if (vecs[v].we) chk("vec_din", 32'(mdin_p), 32'(vecs[v].din));
            check_ack(1'b0, "vec_grant");
            e.port = vecs[v].port;
            e.rd   = vecs[v].exp_rd;
            sbq.push_back(e);
            end_slot();
            tick_slot();
            check_ack(1'b1, "vec");
            chk("vec_idle_after", 32'(moe_p | mwe_p), 32'd0);
            req[vecs[v].port] = 1'b0;
            end_slot();
        end

        // Port 0 idle, ports 1 and 2 held: grants alternate.
        set_port(1, 1'b0, 25'h110, 8'h00);
        set_port(2, 1'b0, 25'h210, 8'h00);
        req  = 3'b110;
        prev = -1;
        for (int s = 0; s < 6; s++) begin
            tick_slot();
            chk("alt_oe", 32'(moe_p), 32'd1);
            g = int'(maddr_p[9:8]);
            if (prev < 0) chk("alt_first", 32'((g == 1) || (g == 2)), 32'd1);
            else          chk("alt_order", 32'(g), 32'(3 - prev));
            prev = g;
            end_slot();
        end
        req = '0;
        repeat (2) begin tick_slot(); end_slot(); end

        // Port 2 withdraws its request one cycle after being granted.
        set_port(2, 1'b0, 25'h00000AA, 8'h00);
        req[2] = 1'b1;
        tick_slot();
        chk("wd_grant", 32'(maddr_p), 32'h0AA);
        chk("wd_oe",    32'(moe_p),   32'd1);
        e.port = 2;
        e.rd   = 8'hD3;
        sbq.push_back(e);
        @(negedge clk);
        req[2] = 1'b0;
        end_slot();
        tick_slot();
        check_ack(1'b1, "wd");
        chk("wd_no_regrant", 32'(moe_p), 32'd0);
        end_slot();
        tick_slot();
        check_ack(1'b0, "wd_later");
        chk("wd_still_idle", 32'(moe_p), 32'd0);
        end_slot();

        // Asynchronous reset while an access is in flight.
        set_port(1, 1'b0, 25'h0000042, 8'h00);
        req[1] = 1'b1;
        tick_slot();
        chk("ar_grant_oe", 32'(moe_p), 32'd1);
        @(negedge clk);
        clkref = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_oe",    32'(moe_p),   32'd0);
        chk("ar_addr",  32'(maddr_p), 32'd0);
        chk("ar_ack",   32'(ack_p),   32'd0);
        chk("ar_rdata", 32'(rdata_p), 32'd0);
        sbq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tick_slot();
        check_ack(1'b0, "ar_first_sb");
        chk("ar_regrant_oe",   32'(moe_p),   32'd1);
        chk("ar_regrant_addr", 32'(maddr_p), 32'h042);
        e.port = 1;
        e.rd   = 8'h3B;
        sbq.push_back(e);
        end_slot();
        tick_slot();
        check_ack(1'b1, "ar");
        req = '0;
        end_slot();

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
